cpu2core_timer_service: RTL
===========================

# cpu2core_timer_service

Avalon-MM master that initialises and services the 16-bit-data interval timer peripheral (3-bit address, no waitrequest, registered readdata) on behalf of the second core. After reset it programs the period, clears stale status, sets the interrupt-enable bit and reads it back. It then answers every timer `irq` by reading and clearing status in hardware, and exposes a free-running tick count and a one-cycle tick strobe to the core fabric.

## Interface
- `PERIOD_L`, 16'h0031: value written to timer address 2 during init.
- `PERIOD_H`, 16'h0000: value written to timer address 3 during init.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset (sampled on `clk` rising edge).
- `irq_enable`  in  1  requested state of the timer control bit 0.
- `irq`  in  1  timer interrupt.
- `readdata`  in  16  timer read data, valid the cycle after the read address is presented.
- `address`  out  3  timer register select (0 status, 1 control, 2 period_l, 3 period_h).
- `chipselect`  out  1  transaction valid.
- `write_n`  out  1  active-low write; 1 during reads and idle.
- `writedata`  out  16  write data.
- `init_done`  out  1  high once init completes; stays high until reset.
- `cfg_error`  out  1  sticky: control readback mismatched.
- `tick_pulse`  out  1  one-cycle strobe per serviced timeout.
- `tick_count`  out  32  serviced timeouts, wraps modulo 2^32.
- `spurious_count`  out  8  irq services whose status bit 0 read 0; saturates at 255.
- `timer_running`  out  1  status bit 1 captured at the last status read.

## Operation
- Each bus transaction lasts exactly 1 cycle (no waitrequest). Write: `chipselect`=1, `write_n`=0. Read: `chipselect`=1, `write_n`=1, then a WAIT cycle with `chipselect`=0 and `address` held. `readdata` is sampled at the end of WAIT.
- FSM states: I_PL, I_PH, I_CLR, I_CTRL, I_VRD, I_VWAIT, IDLE, S_RD, S_WAIT, S_CLR, C_WR.
- Init path, one state per cycle:
  - I_PL writes addr 2 = `PERIOD_L`.
  - I_PH writes addr 3 = `PERIOD_H`.
  - I_CLR writes addr 0 = 0.
  - I_CTRL writes addr 1 = {15'b0, `irq_enable`} and latches the shadow bit.
  - I_VRD reads addr 1.
  - I_VWAIT: if `readdata[0]` differs from the shadow, set `cfg_error`. Then go to IDLE and set `init_done`.
- IDLE priority:
  - `irq`=1 goes to S_RD.
  - Otherwise, `irq_enable` differing from the shadow goes to C_WR.
  - Otherwise, stay in IDLE.
- C_WR writes addr 1 = {15'b0, `irq_enable`}, updates the shadow, then goes to IDLE. No readback.
- S_RD reads addr 0.
- S_WAIT captures `timer_running` = `readdata[1]`.
  - If `readdata[0]`=1, go to S_CLR.
  - Otherwise, increment `spurious_count` (saturating) and go to IDLE.
- S_CLR writes addr 0 = 0, increments `tick_count`, asserts `tick_pulse` on the following cycle, then goes to IDLE.
- `irq` is ignored outside IDLE. The timer clears its flag at the S_CLR edge, so `irq` is already low in the next IDLE cycle and the service is not re-entered.
- A timeout that coincides with the S_CLR write is lost inside the timer. The block does not compensate; this is accepted because the period is at least 50 cycles and the service takes 4.

## Timing
- Reset values: `address`=0, `chipselect`=0, `write_n`=1, `writedata`=0, `init_done`=0, `cfg_error`=0, `tick_pulse`=0, `tick_count`=0, `spurious_count`=0, `timer_running`=0. FSM resets to I_PL.
- Reset release at edge E0: the I_PL write occupies cycle 0, and `init_done` is high from cycle 6.
- `irq` high in an IDLE cycle T gives:
  - S_RD at T+1;
  - S_WAIT at T+2;
  - S_CLR at T+3;
  - `tick_pulse` and the new `tick_count` visible at T+4.
- `irq` and a control change in the same IDLE cycle: service first, C_WR follows the next IDLE cycle.
- Reset asserted mid-transaction drops `chipselect` on the next edge and restarts the full init sequence. Counters clear.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset release with `irq_enable`=1 and a timer model that returns written values:
  - exact sequence (2,w,0x0031), (3,w,0x0000), (0,w,0), (1,w,1), (1,r);
  - `init_done` at cycle 6; `cfg_error`=0.
- Timer model counting period 0x31 (50 cycles): 3 timeouts give `tick_count`=3 and 3 `tick_pulse`s, each 4 cycles after `irq`; `timer_running`=1.
- `irq` forced high while the model's status bit 0 is 0: `spurious_count`=1, no addr-0 write, return to IDLE.
- Toggle `irq_enable` 1→0 in IDLE: single write (1,w,0), after which `irq` stays low and `tick_count` is frozen.
- Model returns control bit 0 = 0 on readback: `cfg_error`=1 and sticky; servicing still works.
- Assert `reset_n` during S_WAIT: all outputs return to reset values; the init sequence replays from (2,w,0x0031).

Source files
------------

// File: rtl/cpu2core_timer_service.sv
// cpu2core_timer_service
// Avalon-MM master that brings up the interval timer for the second core and
// then services every timer interrupt in hardware. After reset it programs the
// period, clears stale status, writes the interrupt-enable bit and reads it
// back. Each irq is answered by a status read followed, for a real timeout, by
// a status clear. The core fabric sees a tick counter and a one-cycle strobe.
//
// All bus outputs are registered and are loaded from the state being entered,
// so the register `state` always names the state whose bus cycle is visible
// during the current clock period. The `started` flag holds the FSM in I_PL
// for the first edge after reset, which places the I_PL write in cycle 0.

module cpu2core_timer_service #(
    parameter logic [15:0] PERIOD_L = 16'h0031,
    parameter logic [15:0] PERIOD_H = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq_enable,
    input  logic        irq,
    input  logic [15:0] readdata,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    output logic        init_done,
    output logic        cfg_error,
    output logic        tick_pulse,
    output logic [31:0] tick_count,
    output logic [7:0]  spurious_count,
    output logic        timer_running
);

    // Timer register map.
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

    // FSM encoding.
    localparam logic [3:0] I_PL    = 4'd0;
    localparam logic [3:0] I_PH    = 4'd1;
    localparam logic [3:0] I_CLR   = 4'd2;
    localparam logic [3:0] I_CTRL  = 4'd3;
    localparam logic [3:0] I_VRD   = 4'd4;
    localparam logic [3:0] I_VWAIT = 4'd5;
    localparam logic [3:0] IDLE    = 4'd6;
    localparam logic [3:0] S_RD    = 4'd7;
    localparam logic [3:0] S_WAIT  = 4'd8;
    localparam logic [3:0] S_CLR   = 4'd9;
    localparam logic [3:0] C_WR    = 4'd10;

    logic [3:0]  state;
    logic [3:0]  next_state;
    logic        started;
    logic        shadow_enable;

    logic        bus_cs;
    logic        bus_wn;
    logic        bus_load_addr;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;

    // Only status bits 0 and 1 carry meaning for this master.
    logic        unused_readdata;
    assign unused_readdata = &{1'b0, readdata[15:2]};

    // Next-state selection; IDLE gives an interrupt priority over a control update.
    always_comb begin
        next_state = state;
        if (!started) begin
            next_state = I_PL;
        end else begin
            case (state)
                I_PL:    next_state = I_PH;
                I_PH:    next_state = I_CLR;
                I_CLR:   next_state = I_CTRL;
                I_CTRL:  next_state = I_VRD;
                I_VRD:   next_state = I_VWAIT;
                I_VWAIT: next_state = IDLE;
                IDLE: begin
                    if (irq) begin
                        next_state = S_RD;
                    end else if (irq_enable != shadow_enable) begin
                        next_state = C_WR;
                    end else begin
                        next_state = IDLE;
                    end
                end
                S_RD:    next_state = S_WAIT;
                S_WAIT:  next_state = readdata[0] ? S_CLR : IDLE;
                S_CLR:   next_state = IDLE;
                C_WR:    next_state = IDLE;
                default: next_state = I_PL;
            endcase
        end
    end

    // Bus cycle belonging to the state about to be entered; waits and idle hold the address.
    always_comb begin
        bus_cs        = 1'b0;
        bus_wn        = 1'b1;
        bus_load_addr = 1'b0;
        bus_addr      = ADDR_STATUS;
        bus_wdata     = 16'h0000;
        case (next_state)
            I_PL: begin
                bus_cs        = 1'b1;
                bus_wn        = 1'b0;
                bus_load_addr = 1'b1;
                bus_addr      = ADDR_PERIOD_L;
                bus_wdata     = PERIOD_L;
            end
            I_PH: begin
                bus_cs        = 1'b1;
                bus_wn        = 1'b0;
                bus_load_addr = 1'b1;
                bus_addr      = ADDR_PERIOD_H;
                bus_wdata     = PERIOD_H;
            end
            I_CLR, S_CLR: begin
                bus_cs        = 1'b1;
                bus_wn        = 1'b0;
                bus_load_addr = 1'b1;
                bus_addr      = ADDR_STATUS;
                bus_wdata     = 16'h0000;
            end
            I_CTRL, C_WR: begin
                bus_cs        = 1'b1;
                bus_wn        = 1'b0;
                bus_load_addr = 1'b1;
                bus_addr      = ADDR_CONTROL;
                bus_wdata     = {15'b0, irq_enable};
            end
            I_VRD: begin
                bus_cs        = 1'b1;
                bus_load_addr = 1'b1;
                bus_addr      = ADDR_CONTROL;
            end
            S_RD: begin
                bus_cs        = 1'b1;
                bus_load_addr = 1'b1;
                bus_addr      = ADDR_STATUS;
            end
            default: begin
                bus_cs        = 1'b0;
            end
        endcase
    end

    // Registered Avalon outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            address    <= 3'd0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= 16'h0000;
        end else begin
            chipselect <= bus_cs;
            write_n    <= bus_wn;
            writedata  <= bus_wdata;
            if (bus_load_addr) begin
                address <= bus_addr;
            end
        end
    end

    // FSM state plus the shadow of the control bit last written to the timer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= I_PL;
            started       <= 1'b0;
            shadow_enable <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
            if (next_state == I_CTRL || next_state == C_WR) begin
                shadow_enable <= irq_enable;
            end
        end
    end

    // Init completion and sticky readback check at the end of the verify wait.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            init_done <= 1'b0;
            cfg_error <= 1'b0;
        end else if (state == I_VWAIT) begin
            init_done <= 1'b1;
            if (readdata[0] != shadow_enable) begin
                cfg_error <= 1'b1;
            end
        end
    end

    // Interrupt service bookkeeping: run flag, spurious and tick counters, tick strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_running  <= 1'b0;
            spurious_count <= 8'd0;
            tick_count     <= 32'd0;
            tick_pulse     <= 1'b0;
        end else begin
            tick_pulse <= (state == S_CLR);
            if (state == S_CLR) begin
                tick_count <= tick_count + 32'd1;
            end
            if (state == S_WAIT) begin
                timer_running <= readdata[1];
                if (!readdata[0] && spurious_count != 8'hFF) begin
                    spurious_count <= spurious_count + 8'd1;
                end
            end
        end
    end

endmodule
